// File: rtl/core_round_scheduler_if.sv
// core_round_scheduler_if: job request, core status and core control bundle
// for core_round_scheduler. The scheduler connects through the slave modport,
// the job source / core array through the master modport.
interface core_round_scheduler_if #(
  parameter int unsigned NO_OF_CORES = 5,
  parameter int unsigned ROW_CNT_LEN = 8,
  parameter int unsigned ADDRESS_LEN = 12
);
  logic                               start;
  logic [ROW_CNT_LEN-1:0]             total_rows;
  logic [ADDRESS_LEN*NO_OF_CORES-1:0] core_address;
  logic [NO_OF_CORES-1:0]             finish_cores;
  logic [NO_OF_CORES-1:0]             start_cores;
  logic [NO_OF_CORES-1:0]             reset_cores;
  logic [NO_OF_CORES-1:0]             active_mask;
  logic [ROW_CNT_LEN-1:0]             row_base;
  logic                               busy;
  logic                               finish_process;
  logic                               error;

  modport master (
    output start, total_rows, core_address, finish_cores,
    input  start_cores, reset_cores, active_mask, row_base, busy, finish_process, error
  );

  modport slave (
    input  start, total_rows, core_address, finish_cores,
    output start_cores, reset_cores, active_mask, row_base, busy, finish_process, error
  );
endinterface

// File: rtl/core_round_scheduler.sv
// core_round_scheduler: splits a job of total_rows rows across NO_OF_CORES
// cores in rounds. Each round the active cores are started one at a time until
// each passes its exclusive load phase (RAM address == LOAD_DONE_ADDR), then
// released together; when all active cores finish they are reset and the next
// round is allocated. All outputs are registered.
// Optional feature macro: STAGGER_TIMEOUT_EN (stagger watchdog driving error).
module core_round_scheduler #(
  parameter int unsigned NO_OF_CORES        = 5,
  parameter int unsigned ROW_CNT_LEN        = 8,
  parameter int unsigned ADDRESS_LEN        = 12,
  parameter int unsigned LOAD_DONE_ADDR     = 23,
  parameter int unsigned RESET_PULSE_CYCLES = 2,
  parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
  input logic                   clk,
  input logic                   reset,
  core_round_scheduler_if.slave bus
);

  localparam int unsigned IDX_W   = $clog2(NO_OF_CORES + 1);
  localparam int unsigned PULSE_W = (RESET_PULSE_CYCLES > 1) ? $clog2(RESET_PULSE_CYCLES) : 1;
`ifdef STAGGER_TIMEOUT_EN
  localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALLOC,
    S_STAGGER,
    S_RUN,
    S_CORE_RST,
    S_DONE
  } state_t;

  state_t                 r_state,       w_state_nxt;
  logic [NO_OF_CORES-1:0] r_start_cores, w_start_cores_nxt;
  logic [NO_OF_CORES-1:0] r_reset_cores, w_reset_cores_nxt;
  logic [NO_OF_CORES-1:0] r_active_mask, w_active_mask_nxt;
  logic [ROW_CNT_LEN-1:0] r_row_base,    w_row_base_nxt;
  logic [ROW_CNT_LEN-1:0] r_rows_left,   w_rows_left_nxt;
  logic                   r_busy,        w_busy_nxt;
  logic                   r_finish,      w_finish_nxt;
  logic                   r_error,       w_error_nxt;
  logic [IDX_W-1:0]       r_n,           w_n_nxt;
  logic [IDX_W-1:0]       r_idx,         w_idx_nxt;
  logic [PULSE_W-1:0]     r_pulse_cnt,   w_pulse_cnt_nxt;
`ifdef STAGGER_TIMEOUT_EN
  logic [TO_W-1:0]        r_to_cnt,      w_to_cnt_nxt;
`endif

  logic [IDX_W-1:0]       w_n_alloc;
  logic [IDX_W-1:0]       w_idx_inc;
  logic [ADDRESS_LEN-1:0] w_cur_addr;
  logic                   w_addr_hit;
  logic                   w_all_done;
  logic [ROW_CNT_LEN-1:0] w_rows_dec;
  logic                   w_unused_cfg;

  // Round size, stagger pointer arithmetic and completion detection
  always_comb begin
    w_n_alloc  = (32'(r_rows_left) < NO_OF_CORES) ? IDX_W'(r_rows_left) : IDX_W'(NO_OF_CORES);
    w_idx_inc  = IDX_W'(r_idx + IDX_W'(1));
    w_cur_addr = ADDRESS_LEN'(bus.core_address >> (ADDRESS_LEN * 32'(r_idx)));
    w_addr_hit = (w_cur_addr == ADDRESS_LEN'(LOAD_DONE_ADDR));
    w_all_done = ((bus.finish_cores & r_active_mask) == r_active_mask);
    w_rows_dec = ROW_CNT_LEN'(r_rows_left - ROW_CNT_LEN'(r_n));
  end

  // TIMEOUT_CYCLES only matters when the watchdog is built in
  assign w_unused_cfg = ^(32'(TIMEOUT_CYCLES));

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt       = r_state;
    w_start_cores_nxt = r_start_cores;
    w_reset_cores_nxt = r_reset_cores;
    w_active_mask_nxt = r_active_mask;
    w_row_base_nxt    = r_row_base;
    w_rows_left_nxt   = r_rows_left;
    w_busy_nxt        = r_busy;
    w_finish_nxt      = r_finish;
    w_error_nxt       = r_error;
    w_n_nxt           = r_n;
    w_idx_nxt         = r_idx;
    w_pulse_cnt_nxt   = r_pulse_cnt;
`ifdef STAGGER_TIMEOUT_EN
    w_to_cnt_nxt      = r_to_cnt;
`endif

    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_rows_left_nxt = bus.total_rows;
          w_row_base_nxt  = '0;
          w_finish_nxt    = 1'b0;
          w_error_nxt     = 1'b0;
          w_busy_nxt      = 1'b1;
          w_state_nxt     = S_ALLOC;
        end
      end

      S_ALLOC: begin
        if (r_rows_left == '0) begin
          // Empty job completes without touching the cores
          w_finish_nxt      = 1'b1;
          w_busy_nxt        = 1'b0;
          w_start_cores_nxt = '0;
          w_active_mask_nxt = '0;
          w_state_nxt       = S_DONE;
        end else begin
          w_n_nxt           = w_n_alloc;
          w_active_mask_nxt = NO_OF_CORES'((32'd1 << w_n_alloc) - 32'd1);
          w_idx_nxt         = '0;
          w_start_cores_nxt = NO_OF_CORES'(1);
`ifdef STAGGER_TIMEOUT_EN
          w_to_cnt_nxt      = '0;
`endif
          w_state_nxt       = S_STAGGER;
        end
      end

      S_STAGGER: begin
        if (w_addr_hit) begin
`ifdef STAGGER_TIMEOUT_EN
          w_to_cnt_nxt = '0;
`endif
          if (r_idx == IDX_W'(r_n - IDX_W'(1))) begin
            w_start_cores_nxt = r_active_mask;
            w_state_nxt       = S_RUN;
          end else begin
            w_idx_nxt         = w_idx_inc;
            w_start_cores_nxt = NO_OF_CORES'(32'd1 << w_idx_inc);
          end
        end
`ifdef STAGGER_TIMEOUT_EN
        else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          w_error_nxt       = 1'b1;
          w_finish_nxt      = 1'b1;
          w_busy_nxt        = 1'b0;
          w_start_cores_nxt = '0;
          w_active_mask_nxt = '0;
          w_state_nxt       = S_DONE;
        end else begin
          w_to_cnt_nxt = TO_W'(r_to_cnt + TO_W'(1));
        end
`endif
      end

      S_RUN: begin
        if (w_all_done) begin
          w_rows_left_nxt   = w_rows_dec;
          w_row_base_nxt    = ROW_CNT_LEN'(r_row_base + ROW_CNT_LEN'(r_n));
          w_start_cores_nxt = '0;
          if (w_rows_dec == '0) begin
            w_finish_nxt      = 1'b1;
            w_busy_nxt        = 1'b0;
            w_active_mask_nxt = '0;
            w_state_nxt       = S_DONE;
          end else begin
            w_reset_cores_nxt = r_active_mask;
            w_pulse_cnt_nxt   = '0;
            w_state_nxt       = S_CORE_RST;
          end
        end
      end

      S_CORE_RST: begin
        if (r_pulse_cnt == PULSE_W'(RESET_PULSE_CYCLES - 1)) begin
          w_reset_cores_nxt = '0;
          w_state_nxt       = S_ALLOC;
        end else begin
          w_pulse_cnt_nxt = PULSE_W'(r_pulse_cnt + PULSE_W'(1));
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_start_cores <= '0;
      r_reset_cores <= '0;
      r_active_mask <= '0;
      r_row_base    <= '0;
      r_rows_left   <= '0;
      r_busy        <= 1'b0;
      r_finish      <= 1'b0;
      r_error       <= 1'b0;
      r_n           <= '0;
      r_idx         <= '0;
      r_pulse_cnt   <= '0;
`ifdef STAGGER_TIMEOUT_EN
      r_to_cnt      <= '0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_start_cores <= w_start_cores_nxt;
      r_reset_cores <= w_reset_cores_nxt;
      r_active_mask <= w_active_mask_nxt;
      r_row_base    <= w_row_base_nxt;
      r_rows_left   <= w_rows_left_nxt;
      r_busy        <= w_busy_nxt;
      r_finish      <= w_finish_nxt;
      r_error       <= w_error_nxt;
      r_n           <= w_n_nxt;
      r_idx         <= w_idx_nxt;
      r_pulse_cnt   <= w_pulse_cnt_nxt;
`ifdef STAGGER_TIMEOUT_EN
      r_to_cnt      <= w_to_cnt_nxt;
`endif
    end
  end

  assign bus.start_cores    = r_start_cores;
  assign bus.reset_cores    = r_reset_cores;
  assign bus.active_mask    = r_active_mask;
  assign bus.row_base       = r_row_base;
  assign bus.busy           = r_busy;
  assign bus.finish_process = r_finish;
  assign bus.error          = r_error;

endmodule

// File: tb/tb_core_round_scheduler.sv
// tb_core_round_scheduler: directed job sequence plus randomized jobs. The
// bench plays the cores (random load latencies and finish patterns) and
// predicts each round's mask/row_base from the row-splitting rules.
module tb_core_round_scheduler;

  localparam int unsigned NC  = 5;
  localparam int unsigned RW  = 8;
  localparam int unsigned AW  = 12;
  localparam int unsigned LDA = 23;
  localparam int unsigned RPC = 2;
  localparam int unsigned TO  = 16;
  localparam int unsigned CAW = AW * NC;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned n_pass = 0;
  int unsigned n_fail = 0;
  int unsigned n_chk  = 0;

  core_round_scheduler_if #(.NO_OF_CORES(NC), .ROW_CNT_LEN(RW), .ADDRESS_LEN(AW)) bus ();

  core_round_scheduler #(
    .NO_OF_CORES(NC), .ROW_CNT_LEN(RW), .ADDRESS_LEN(AW), .LOAD_DONE_ADDR(LDA),
    .RESET_PULSE_CYCLES(RPC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [NC-1:0] sc, input logic [NC-1:0] rc,
                            input logic [NC-1:0] am, input logic [RW-1:0] rb,
                            input logic bsy, input logic fp, input logic err);
    check({tag, ".start_cores"}, 32'(bus.start_cores), 32'(sc));
    check({tag, ".reset_cores"}, 32'(bus.reset_cores), 32'(rc));
    check({tag, ".active_mask"}, 32'(bus.active_mask), 32'(am));
    check({tag, ".row_base"}, 32'(bus.row_base), 32'(rb));
    check({tag, ".busy"}, 32'(bus.busy), 32'(bsy));
    check({tag, ".finish_process"}, 32'(bus.finish_process), 32'(fp));
    check({tag, ".error"}, 32'(bus.error), 32'(err));
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, (1 << AW) - 1));
    if (a == AW'(LDA)) a = AW'(LDA + 1);
    return a;
  endfunction

  task automatic set_addr(input int k, input logic [AW-1:0] v);
    logic [CAW-1:0] t;
    logic [CAW-1:0] fld;
    fld = CAW'({AW{1'b1}});
    t   = bus.core_address;
    t   = t & ~(fld << (AW * k));
    t   = t | (CAW'(v) << (AW * k));
    bus.core_address = t;
  endtask

  task automatic scramble_addrs();
    for (int k = 0; k < int'(NC); k++) set_addr(k, rand_addr());
  endtask

  // Runs one job from a negedge; optionally pulses start during RUN or
  // aborts with reset in the first RUN phase.
  task automatic run_job(input int unsigned rows, input bit inject_start, input bit abort_in_run);
    int unsigned    rem;
    int unsigned    base;
    int unsigned    n;
    int unsigned    d;
    logic [NC-1:0]  mask;
    logic [NC-1:0]  onehot;
    logic [NC-1:0]  partial;
    rem  = rows;
    base = 0;
    scramble_addrs();
    bus.finish_cores = '0;
    bus.total_rows   = RW'(rows);
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.total_rows = RW'($urandom);
    check_outs("accept", '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    if (rows == 0) begin
      @(negedge clk);
      check_outs("zero_done", '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
      return;
    end
    while (rem > 0) begin
      n    = (rem < NC) ? rem : NC;
      mask = NC'((32'd1 << n) - 32'd1);
      @(negedge clk);
      for (int k = 0; k < int'(n); k++) begin
        onehot = NC'(32'd1 << k);
        d = $urandom_range(0, 3);
        repeat (d) begin
          check_outs("stagger_wait", onehot, '0, mask, RW'(base), 1'b1, 1'b0, 1'b0);
          @(negedge clk);
        end
        check_outs("stagger_hit", onehot, '0, mask, RW'(base), 1'b1, 1'b0, 1'b0);
        set_addr(k, AW'(LDA));
        @(negedge clk);
        set_addr(k, rand_addr());
      end
      d = $urandom_range(1, 4);
      for (int i = 0; i < int'(d); i++) begin
        partial = NC'($urandom) & mask;
        if (partial == mask) partial = partial & ~NC'(32'd1 << $urandom_range(0, n - 1));
        partial = partial | (($urandom_range(0, 1) == 1) ? ~mask : (NC'($urandom) & ~mask));
        bus.finish_cores = partial;
        check_outs("run_wait", mask, '0, mask, RW'(base), 1'b1, 1'b0, 1'b0);
        if (abort_in_run) begin
          reset = 1'b1;
          #1;
          check_outs("abort", '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
          @(negedge clk);
          reset = 1'b0;
          bus.finish_cores = '0;
          return;
        end
        bus.start      = inject_start && (i == 0);
        bus.total_rows = RW'(9);
        @(negedge clk);
        bus.start = 1'b0;
      end
      bus.finish_cores = mask | (NC'($urandom) & ~mask);
      @(negedge clk);
      bus.finish_cores = '0;
      rem  = rem - n;
      base = (base + n) % (1 << RW);
      if (rem == 0) begin
        check_outs("done", '0, '0, '0, RW'(base), 1'b0, 1'b1, 1'b0);
      end else begin
        repeat (RPC) begin
          check_outs("core_rst", '0, mask, mask, RW'(base), 1'b1, 1'b0, 1'b0);
          @(negedge clk);
        end
        check("realloc.reset_cores", 32'(bus.reset_cores), 32'd0);
        check("realloc.start_cores", 32'(bus.start_cores), 32'd0);
        scramble_addrs();
      end
    end
  endtask

  initial begin
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.total_rows   = '0;
    bus.finish_cores = '0;
    bus.core_address = '0;
    scramble_addrs();
    repeat (2) @(negedge clk);
    check_outs("in_reset", '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check_outs("idle", '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);

    run_job(7, 1'b0, 1'b1);
    check_outs("post_abort", '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    run_job(3, 1'b0, 1'b0);
    run_job(12, 1'b0, 1'b0);
    run_job(0, 1'b0, 1'b0);
    run_job(2, 1'b1, 1'b0);
    run_job(5, 1'b1, 1'b0);

`ifdef STAGGER_TIMEOUT_EN
    scramble_addrs();
    bus.total_rows = RW'(3);
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check_outs("to_idx0", NC'(1), '0, NC'(7), '0, 1'b1, 1'b0, 1'b0);
    set_addr(0, AW'(LDA));
    @(negedge clk);
    set_addr(0, rand_addr());
    repeat (TO) begin
      check_outs("to_wait", NC'(2), '0, NC'(7), '0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
    end
    check_outs("to_fire", '0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
    run_job(3, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 6; i++) begin
      run_job($urandom_range(1, 23), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/core_round_scheduler.md
Name: core_round_scheduler

Overview:
- Sequential dispatcher that splits a job of `total_rows` rows across the processing cores in rounds.
- It runs the cores that share the common RAM. It starts them one at a time until each passes its load phase, then releases them together.
- It waits for every active core to finish, resets them, and repeats until all rows are processed.
- It replaces the ad-hoc combinational start/reset sequencing in the processor top level with a clocked FSM.

Parameters:
- NO_OF_CORES, 5, number of cores driven; 1..15.
- ROW_CNT_LEN, 8, width of row counters.
- ADDRESS_LEN, 12, width of each core's RAM address bus.
- LOAD_DONE_ADDR, 23, address at which a core has finished its exclusive load phase.
- RESET_PULSE_CYCLES, 2, cycles `reset_cores` is held between rounds; ≥1.
- TIMEOUT_CYCLES, 1024, stagger watchdog limit; used only with STAGGER_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  job request, sampled in IDLE/DONE only.
- total_rows  in  ROW_CNT_LEN  rows in the job, latched on accepted start.
- core_address  in  ADDRESS_LEN*NO_OF_CORES  packed RAM address of each core; core c at [ADDRESS_LEN*c +: ADDRESS_LEN].
- finish_cores  in  NO_OF_CORES  per-core finish level.
- start_cores  out  NO_OF_CORES  per-core run enable.
- reset_cores  out  NO_OF_CORES  per-core reset, active-high.
- active_mask  out  NO_OF_CORES  cores participating in the current round.
- row_base  out  ROW_CNT_LEN  row index assigned to core 0 this round; core c handles row_base+c.
- busy  out  1  high from accepted start until DONE.
- finish_process  out  1  job complete, held until next accepted start.
- error  out  1  stagger timeout flag; constant 0 without STAGGER_TIMEOUT_EN.

Behaviour:
- Reset (async) forces:
  - State IDLE.
  - start_cores=0, reset_cores=0, active_mask=0, row_base=0.
  - busy=0, finish_process=0, error=0.
  - Internal rows_left=0, stagger_idx=0, pulse counter=0.
- All outputs are registered. Reset asserted mid-operation aborts the job immediately; no partial completion is reported.
- IDLE / DONE, on start=1:
  - Latch rows_left=total_rows, set row_base=0, clear finish_process and error, set busy=1.
  - If total_rows==0, go to DONE next cycle with finish_process=1 and busy=0.
  - Otherwise go to ALLOC.
- ALLOC (1 cycle):
  - n = min(rows_left, NO_OF_CORES).
  - active_mask = lowest n bits set; stagger_idx=0.
  - Go to STAGGER.
- STAGGER:
  - start_cores = one-hot(stagger_idx); all other cores are held off.
  - When core_address[stagger_idx] == LOAD_DONE_ADDR is sampled: if stagger_idx==n-1, go to RUN; else stagger_idx+1.
  - Each advance takes effect the cycle after the match. The comparison is exact, on the full ADDRESS_LEN bits.
- RUN:
  - start_cores = active_mask.
  - Wait until (finish_cores & active_mask) == active_mask. Inactive cores' finish bits are ignored.
  - On completion: rows_left -= n and row_base += n, both modulo 2^ROW_CNT_LEN. Row counts must not exceed the counter width.
  - Then: rows_left==0 → DONE; else → CORE_RST.
- CORE_RST:
  - start_cores=0; reset_cores=active_mask for exactly RESET_PULSE_CYCLES cycles.
  - Then reset_cores=0 and go to ALLOC.
- DONE:
  - finish_process=1, busy=0, start_cores=0, active_mask=0.
  - The FSM remains here until start.
- start while busy is ignored.
- Partial final round (rows_left < NO_OF_CORES): cores ≥ n receive start_cores=0 and reset_cores=0 throughout.
- Latency:
  - Start to first start_cores bit: 2 cycles (IDLE→ALLOC→STAGGER).
  - Finish of the last round to finish_process: 1 cycle.

Optional Feature:
- Macro: STAGGER_TIMEOUT_EN.
- Defined:
  - A counter restarts at each STAGGER index change.
  - If it reaches TIMEOUT_CYCLES without a match: error=1, start_cores=0, and go to DONE with finish_process=1.
  - error holds until the next accepted start or reset.
- Undefined:
  - No counter; STAGGER waits indefinitely.
  - error is tied to 0.

Test Plan:
- Reset mid-RUN with total_rows=7: assert reset → same cycle all outputs 0, state IDLE; a following start with total_rows=3 runs normally.
- total_rows=3, cores reach addr 23 at staggered times → start_cores goes 001, 010, 100 (one hot), then 111 in RUN. finish_cores=111 → finish_process=1 one cycle later, row_base=3, reset_cores never asserted.
- total_rows=12, NO_OF_CORES=5 → rounds with active_mask 11111, 11111, 00011 and row_base 0, 5, 10. reset_cores=active_mask for 2 cycles between rounds. finish_process after the third round.
- total_rows=0 → finish_process=1 two cycles after start, start_cores never nonzero.
- During RUN with total_rows=2, finish_cores=11100 (inactive cores only) → no progress. finish_cores=00011 → DONE. start pulse while busy → ignored.
- STAGGER_TIMEOUT_EN, TIMEOUT_CYCLES=16, core 1 never reaches 23 → error=1 and finish_process=1 after 16 cycles in stagger index 1, start_cores=0.
